// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, states,
// datapath steering codes and the decoded opcode class.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_FUNCT  = 2'd1;
    localparam logic [1:0] ALU_CMP    = 2'd2;
    localparam logic [1:0] ALU_PASS_B = 2'd3;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    typedef enum logic [3:0] {
        CL_NONE,
        CL_OP,
        CL_OP_IMM,
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR,
        CL_BRANCH,
        CL_LOAD,
        CL_STORE,
        CL_FENCE,
        CL_SYSTEM,
        CL_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode/funct3 legality check and instruction classification.
module op_classify
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output op_class_t  op_class
);

    // Anything not explicitly recognised falls through as illegal.
    always_comb begin
        op_class = CL_ILLEGAL;
        case (opcode)
            OPC_OP:       op_class = CL_OP;
            OPC_OP_IMM:   op_class = CL_OP_IMM;
            OPC_LUI:      op_class = CL_LUI;
            OPC_AUIPC:    op_class = CL_AUIPC;
            OPC_JAL:      op_class = CL_JAL;
            OPC_JALR:     if (funct3 == 3'b000) op_class = CL_JALR;
            OPC_BRANCH:   if (funct3 != 3'b010 && funct3 != 3'b011) op_class = CL_BRANCH;
            OPC_LOAD:     if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) op_class = CL_LOAD;
            OPC_STORE:    if (funct3 inside {3'b000, 3'b001, 3'b010}) op_class = CL_STORE;
            OPC_MISC_MEM: op_class = CL_FENCE;
            OPC_SYSTEM:   op_class = CL_SYSTEM;
            default:      op_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback
// sequencing, datapath steering and a retired-instruction counter.
module control_fsm
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        branch_cond,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_mode,
    output logic [2:0]  imm_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        trap,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    state_t    cur;
    op_class_t cls;
    op_class_t dec_class;
    logic      run;
    logic      active;
    logic [31:0] count;

    op_classify u_classify (
        .opcode   (opcode),
        .funct3   (funct3),
        .op_class (dec_class)
    );

    // run holds off the first FETCH until rst_n has been sampled high once,
    // and the combinational rst_n term blanks outputs while reset is asserted.
    assign active  = rst_n & run;
    assign state   = cur;
    assign instret = active ? count : 32'd0;

    // State sequencing, opcode-class latch and retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur   <= ST_FETCH;
            cls   <= CL_NONE;
            count <= 32'd0;
            run   <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            case (cur)
                ST_FETCH: begin
                    if (imem_ack) cur <= ST_DECODE;
                end
                ST_DECODE: begin
                    cls <= dec_class;
                    case (dec_class)
                        CL_ILLEGAL, CL_SYSTEM: cur <= ST_TRAP;
                        CL_FENCE:              cur <= ST_WRITEBACK;
                        default:               cur <= ST_EXECUTE;
                    endcase
                end
                ST_EXECUTE: begin
                    case (cls)
                        CL_BRANCH: begin
                            cur   <= ST_FETCH;
                            count <= count + 32'd1;
                        end
                        CL_LOAD, CL_STORE: cur <= ST_MEMORY;
                        default:           cur <= ST_WRITEBACK;
                    endcase
                end
                ST_MEMORY: begin
                    if (dmem_ack) begin
                        if (cls == CL_STORE) begin
                            cur   <= ST_FETCH;
                            count <= count + 32'd1;
                        end else begin
                            cur <= ST_WRITEBACK;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    cur   <= ST_FETCH;
                    count <= count + 32'd1;
                end
                ST_TRAP: cur <= ST_TRAP;
                default: cur <= ST_TRAP;
            endcase
        end
    end

    // Control outputs decoded from state and latched class; only the
    // handshake cycles (ir_load, store pc_write) and branch pc_src look at inputs.
    always_comb begin
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_mode  = ALU_ADD;
        imm_sel   = IMM_I;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        trap      = 1'b0;
        if (active) begin
            case (cur)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ack;
                end
                ST_EXECUTE: begin
                    case (cls)
                        CL_OP: alu_mode = ALU_FUNCT;
                        CL_OP_IMM: begin
                            alu_src_b = 1'b1;
                            alu_mode  = ALU_FUNCT;
                        end
                        CL_LUI: begin
                            alu_src_b = 1'b1;
                            alu_mode  = ALU_PASS_B;
                            imm_sel   = IMM_U;
                        end
                        CL_AUIPC: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 1'b1;
                            imm_sel   = IMM_U;
                        end
                        CL_JAL:  imm_sel = IMM_J;
                        CL_JALR: alu_src_b = 1'b1;
                        CL_LOAD: alu_src_b = 1'b1;
                        CL_STORE: begin
                            alu_src_b = 1'b1;
                            imm_sel   = IMM_S;
                        end
                        CL_BRANCH: begin
                            alu_mode = ALU_CMP;
                            imm_sel  = IMM_B;
                            pc_write = 1'b1;
                            pc_src   = branch_cond ? PC_IMM : PC_PLUS4;
                        end
                        default: ;
                    endcase
                end
                ST_MEMORY: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls == CL_STORE);
                    pc_write = (cls == CL_STORE) && dmem_ack;
                end
                ST_WRITEBACK: begin
                    reg_write = (cls != CL_FENCE);
                    pc_write  = 1'b1;
                    case (cls)
                        CL_LOAD:         wb_sel = WB_MEM;
                        CL_JAL, CL_JALR: wb_sel = WB_PC4;
                        default:         wb_sel = WB_ALU;
                    endcase
                    case (cls)
                        CL_JAL:  pc_src = PC_IMM;
                        CL_JALR: pc_src = PC_ALU;
                        default: pc_src = PC_PLUS4;
                    endcase
                end
                ST_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-instruction phase model checked
// every cycle, plus hand-computed literal checks on selected scenarios.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, branch_cond = 1'b0;
    logic        imem_req, ir_load, dmem_req, dmem_we, alu_src_a, alu_src_b;
    logic [1:0]  alu_mode, wb_sel, pc_src;
    logic [2:0]  imm_sel, state;
    logic        reg_write, pc_write, trap;
    logic [31:0] instret;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .branch_cond(branch_cond),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_mode(alu_mode), .imm_sel(imm_sel),
        .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
        .trap(trap), .state(state), .instret(instret)
    );

    typedef struct packed {
        logic        imem_req, ir_load, dmem_req, dmem_we, alu_src_a, alu_src_b;
        logic [1:0]  alu_mode;
        logic [2:0]  imm_sel;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic        trap;
        logic [2:0]  state;
        logic [31:0] instret;
    } out_t;

    // Instruction kinds as the bench sees them; SYSTEM and illegal both trap.
    localparam int K_OP = 0, K_OPIMM = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4, K_JALR = 5,
                   K_BR = 6, K_LD = 7, K_ST = 8, K_FENCE = 9, K_BAD = 10;
    localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_T = 5;

    out_t act, expv;
    bit   chk_en = 0, chk_state = 0;
    int   tests = 0, fails = 0;
    out_t hist[$];
    logic [31:0] n_ret = 0;

    assign act = {imem_req, ir_load, dmem_req, dmem_we, alu_src_a, alu_src_b, alu_mode, imm_sel,
                  reg_write, wb_sel, pc_write, pc_src, trap, state, instret};

    // Single compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin : cmp
        out_t a, e;
        if (chk_en) begin
            a = act;
            e = expv;
            if (!chk_state) begin
                a.state = '0;
                e.state = '0;
            end
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, a, e);
            end
            hist.push_back(act);
        end
    end

    task automatic lit(input string name, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, a, e);
        end
    endtask

    function automatic int classify(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        case (op)
            7'h33: return K_OP;
            7'h13: return K_OPIMM;
            7'h37: return K_LUI;
            7'h17: return K_AUIPC;
            7'h6F: return K_JAL;
            7'h67: return (f3 == 3'd0) ? K_JALR : K_BAD;
            7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_BAD : K_BR;
            7'h03: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? K_BAD : K_LD;
            7'h23: return (f3 <= 3'd2) ? K_ST : K_BAD;
            7'h0F: return K_FENCE;
            default: return K_BAD;
        endcase
    endfunction

    // Expected outputs for one cycle spent in phase st of an instruction of kind k.
    function automatic out_t model(input int st, input int k, input bit ack, input bit bc,
                                   input logic [31:0] ir);
        out_t o;
        o = '0;
        o.state = 3'(st);
        o.instret = ir;
        case (st)
            S_F: begin o.imem_req = 1; o.ir_load = ack; end
            S_E: case (k)
                K_OP:    o.alu_mode = 2'd1;
                K_OPIMM: begin o.alu_src_b = 1; o.alu_mode = 2'd1; end
                K_LUI:   begin o.alu_src_b = 1; o.alu_mode = 2'd3; o.imm_sel = 3'd3; end
                K_AUIPC: begin o.alu_src_a = 1; o.alu_src_b = 1; o.imm_sel = 3'd3; end
                K_JAL:   o.imm_sel = 3'd4;
                K_JALR:  o.alu_src_b = 1;
                K_LD:    o.alu_src_b = 1;
                K_ST:    begin o.alu_src_b = 1; o.imm_sel = 3'd1; end
                K_BR:    begin o.alu_mode = 2'd2; o.imm_sel = 3'd2; o.pc_write = 1; o.pc_src = {1'b0, bc}; end
                default: ;
            endcase
            S_M: begin
                o.dmem_req = 1;
                o.dmem_we = (k == K_ST);
                o.pc_write = (k == K_ST) && ack;
            end
            S_W: begin
                o.reg_write = (k != K_FENCE);
                o.pc_write = 1;
                o.wb_sel = (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
                o.pc_src = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
            end
            S_T: o.trap = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic step(input bit ia, input bit da, input bit bc, input bit rn,
                        input logic [31:0] w, input out_t e, input bit cs);
        rst_n = rn; imem_ack = ia; dmem_ack = da; branch_cond = bc;
        opcode = w[6:0]; funct3 = w[14:12];
        expv = e; chk_state = cs; chk_en = 1;
        @(posedge clk);
        #1;
    endtask

    // n cycles of rst_n=0, then one release cycle that must stay idle.
    task automatic do_reset(input int n);
        out_t z;
        z = '0;
        n_ret = 0;
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, z, i > 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, z, 1'b1);
    endtask

    // Run one instruction; limit truncates it (for mid-instruction reset).
    task automatic run_instr(input logic [31:0] w, input int ifd, input int dd, input bit bc,
                             input bit spur, input int limit);
        int k, n;
        int sq[$];
        bit aq[$];
        k = classify(w);
        for (int i = 0; i <= ifd; i++) begin sq.push_back(S_F); aq.push_back(i == ifd); end
        sq.push_back(S_D); aq.push_back(0);
        if (k == K_FENCE) begin
            sq.push_back(S_W); aq.push_back(0);
        end else if (k != K_BAD) begin
            sq.push_back(S_E); aq.push_back(0);
            if (k == K_LD || k == K_ST)
                for (int j = 0; j <= dd; j++) begin sq.push_back(S_M); aq.push_back(j == dd); end
            if (k != K_BR && k != K_ST) begin sq.push_back(S_W); aq.push_back(0); end
        end
        hist.delete();
        n = (sq.size() < limit) ? sq.size() : limit;
        for (int i = 0; i < n; i++)
            step((sq[i] == S_F) ? aq[i] : spur, (sq[i] == S_M) ? aq[i] : spur, bc, 1'b1, w,
                 model(sq[i], k, aq[i], bc, n_ret), 1'b1);
        if (n == sq.size() && k != K_BAD) n_ret++;
    endtask

    task automatic trap_hold(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b1, 1'b1, 1'b1, w, model(S_T, K_BAD, 1'b0, 1'b0, n_ret), 1'b1);
    endtask

    logic [31:0] mixed[6] = '{32'h00100093, 32'h000010B7, 32'h00001097, 32'h008000EF,
                              32'h0000000F, 32'h0020A023};
    logic [31:0] bad[4]   = '{32'h00000073, 32'h00003083, 32'h00003023, 32'h00002063};

    initial begin : stim
        int cnt_req, cnt_we, cnt_rw, cnt_tr, cnt_ir;
        do_reset(2);

        // ADD: F D E W, retire count 0 -> 1
        lit("add_instret_before", instret, 32'd0);
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 1000);
        lit("add_len", hist.size(), 4);
        lit("add_states", {hist[0].state, hist[1].state, hist[2].state, hist[3].state}, 12'o0124);
        lit("add_wb", {hist[3].reg_write, hist[3].wb_sel, hist[3].pc_src}, 5'b1_00_00);
        lit("add_instret_after", instret, 32'd1);

        // LW with fetch stall 2, dmem_ack after 3 wait cycles, spurious acks elsewhere
        run_instr(32'h0000A183, 2, 3, 1'b0, 1'b1, 1000);
        cnt_req = 0; cnt_we = 0;
        foreach (hist[i]) begin cnt_req += hist[i].dmem_req; cnt_we += hist[i].dmem_we; end
        lit("lw_dmem_req_cycles", cnt_req, 4);
        lit("lw_dmem_we_cycles", cnt_we, 0);
        lit("lw_wb", {hist[$].state, hist[$].wb_sel}, {3'd4, 2'd1});
        lit("lw_len", hist.size(), 10);

        // BEQ taken / not taken
        run_instr(32'h00208463, 0, 0, 1'b1, 1'b0, 1000);
        cnt_rw = 0;
        foreach (hist[i]) cnt_rw += hist[i].reg_write;
        lit("beq_t_exec", {hist[2].state, hist[2].pc_write, hist[2].pc_src}, {3'd2, 1'b1, 2'd1});
        lit("beq_t_regwrite", cnt_rw, 0);
        run_instr(32'h00208463, 0, 0, 1'b0, 1'b0, 1000);
        lit("beq_nt_exec", {hist[2].pc_write, hist[2].pc_src}, {1'b1, 2'd0});
        lit("beq_len", hist.size(), 3);

        // JALR
        run_instr(32'h000080E7, 0, 0, 1'b0, 1'b0, 1000);
        lit("jalr_wb", {hist[3].state, hist[3].wb_sel, hist[3].pc_src}, {3'd4, 2'd2, 2'd2});
        lit("instret_after_5", instret, 32'd5);

        // Remaining classes, model-checked
        foreach (mixed[i]) run_instr(mixed[i], i % 2, 1, 1'b0, 1'b1, 1000);
        lit("instret_after_11", instret, 32'd11);

        // JALR funct3=001 traps
        run_instr(32'h000090E7, 0, 0, 1'b0, 1'b0, 1000);
        trap_hold(32'h000090E7, 3);
        lit("jalr_f3_trap", {hist[$].state, hist[$].trap}, {3'd5, 1'b1});
        do_reset(1);

        // All-ones word: trap held 20 cycles with no fetch, then one reset cycle
        run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 1000);
        trap_hold(32'hFFFFFFFF, 20);
        cnt_tr = 0; cnt_ir = 0;
        foreach (hist[i]) if (hist[i].trap) begin cnt_tr++; cnt_ir += hist[i].imem_req; end
        lit("ones_trap_cycles", cnt_tr, 20);
        lit("ones_trap_imem_req", cnt_ir, 0);
        do_reset(1);
        lit("ones_after_reset", {hist[$].state, hist[$].trap}, {3'd0, 1'b0});

        // SYSTEM and illegal funct3 variants
        foreach (bad[i]) begin
            run_instr(bad[i], 0, 0, 1'b0, 1'b0, 1000);
            trap_hold(bad[i], 2);
            lit("bad_trap", hist[$].trap, 1'b1);
            do_reset(1);
        end

        // SW stuck in MEMORY, reset mid-access
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 1000);
        run_instr(32'h0020A023, 0, 50, 1'b0, 1'b0, 5);
        lit("sw_in_mem", {hist[$].state, hist[$].dmem_req, hist[$].dmem_we}, {3'd3, 1'b1, 1'b1});
        lit("sw_instret_before", instret, 32'd1);
        do_reset(1);
        lit("sw_rst_state", hist[$].state, 3'd0);
        lit("sw_rst_mem", {hist[$].dmem_req, hist[$].dmem_we}, 2'b00);
        lit("sw_rst_instret", hist[$].instret, 32'd0);

        // Normal operation after reset
        run_instr(32'h0000A183, 1, 0, 1'b0, 1'b0, 1000);
        run_instr(32'h008000EF, 0, 0, 1'b0, 1'b1, 1000);
        lit("final_instret", instret, 32'd2);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
